// File: rtl/noc_input_port_if.sv
// Handshake bundle between the NI, the router input port, the switch allocator and the crossbar.
// The slave view belongs to the input port; the master view belongs to whatever drives it.
interface noc_input_port_if #(
  parameter int DEPTH = 8
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [7:0]       flit_in;
  logic             flit_in_valid;
  logic             noc_ready;
  logic [7:0]       flit_out;
  logic             flit_out_valid;
  logic             flit_out_ready;
  logic [2:0]       route_req;
  logic             route_grant;
  logic             pkt_err;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output flit_in, flit_in_valid, flit_out_ready, route_grant,
    input  noc_ready, flit_out, flit_out_valid, route_req, pkt_err, occupancy
  );

  modport slave (
    input  flit_in, flit_in_valid, flit_out_ready, route_grant,
    output noc_ready, flit_out, flit_out_valid, route_req, pkt_err, occupancy
  );
endinterface

// File: rtl/noc_input_port.sv
// Router input stage: buffers 6-flit packets from the NI, computes an XY route from the header,
// holds the route request until granted, then streams the packet to the crossbar.
module noc_input_port #(
  parameter int         DEPTH      = 8,
  parameter logic [1:0] LOCAL_ADDR = 2'b00,
  parameter logic [5:0] HEADER_TAG = 6'b101111,
  parameter logic [7:0] TAIL_FLIT  = 8'hFF
) (
  input  logic             clk,
  input  logic             rst_n,
  noc_input_port_if.slave  port
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [2:0]  LAST_IDX = 3'd5;

  typedef enum logic [1:0] {
    HEAD_WAIT,
    REQ,
    FWD
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic [7:0]    head;
  logic          header_ok;

  logic [2:0]    route_req_q;
  logic [2:0]    route_req_nxt;
  logic [2:0]    flit_cnt;
  logic [2:0]    flit_cnt_nxt;
  logic          pkt_err_q;
  logic          pkt_err_nxt;

  // X is resolved before Y; a packet addressed to this node goes to the local port.
  function automatic logic [2:0] xy_route(input logic [1:0] dest);
    if (dest[0] != LOCAL_ADDR[0]) begin
      return 3'b010;
    end else if (dest[1] != LOCAL_ADDR[1]) begin
      return 3'b100;
    end
    return 3'b001;
  endfunction

  assign empty     = (occ == '0);
  assign full      = (occ == OCC_FULL);
  assign head      = mem[rd_ptr];
  assign header_ok = (head[7:2] == HEADER_TAG);
  assign push      = port.flit_in_valid && !full;

  assign port.noc_ready      = !full;
  assign port.flit_out       = head;
  assign port.flit_out_valid = (state == FWD) && !empty;
  assign port.route_req      = route_req_q;
  assign port.pkt_err        = pkt_err_q;
  assign port.occupancy      = occ;

  // Storage has no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= port.flit_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HEAD_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // The header is not popped when it is recognised; it leaves as the first flit of FWD.
  always_comb begin
    state_nxt     = state;
    route_req_nxt = route_req_q;
    flit_cnt_nxt  = flit_cnt;
    pkt_err_nxt   = 1'b0;
    pop           = 1'b0;
    case (state)
      HEAD_WAIT: begin
        if (!empty) begin
          if (header_ok) begin
            route_req_nxt = xy_route(head[1:0]);
            state_nxt     = REQ;
          end else begin
            pop         = 1'b1;
            pkt_err_nxt = 1'b1;
          end
        end
      end
      REQ: begin
        if (port.route_grant) begin
          flit_cnt_nxt = 3'd0;
          state_nxt    = FWD;
        end
      end
      FWD: begin
        if (!empty && port.flit_out_ready) begin
          pop = 1'b1;
          if (flit_cnt == LAST_IDX) begin
            pkt_err_nxt   = (head != TAIL_FLIT);
            route_req_nxt = 3'b000;
            flit_cnt_nxt  = 3'd0;
            state_nxt     = HEAD_WAIT;
          end else begin
            flit_cnt_nxt = flit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = HEAD_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      route_req_q <= 3'b000;
      flit_cnt    <= 3'd0;
      pkt_err_q   <= 1'b0;
    end else begin
      route_req_q <= route_req_nxt;
      flit_cnt    <= flit_cnt_nxt;
      pkt_err_q   <= pkt_err_nxt;
    end
  end
endmodule

// File: tb/tb_noc_input_port.sv
// Directed bench for noc_input_port: reset, routing, back-pressure, framing errors, mid-packet reset.
module tb_noc_input_port;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] out_q [$];
  logic [2:0] rr_q [$];
  int         err_cnt = 0;

  noc_input_port_if #(.DEPTH(DEPTH)) bus ();

  noc_input_port #(
    .DEPTH     (DEPTH),
    .LOCAL_ADDR(2'b00),
    .HEADER_TAG(6'b101111),
    .TAIL_FLIT (8'hFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .port (bus.slave)
  );

  always #5 clk = ~clk;

  // Transfers and error pulses are recorded mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.flit_out_valid && bus.flit_out_ready) begin
        out_q.push_back(bus.flit_out);
        rr_q.push_back(bus.route_req);
      end
      if (bus.pkt_err) begin
        err_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] exp_flit(input logic [7:0] hdr, input logic [7:0] tail, input int i);
    case (i)
      0:       return hdr;
      1:       return 8'h11;
      2:       return 8'h22;
      3:       return 8'h33;
      4:       return 8'h44;
      default: return tail;
    endcase
  endfunction

  task automatic apply_reset();
    rst_n              = 1'b0;
    bus.flit_in        = 8'h00;
    bus.flit_in_valid  = 1'b0;
    bus.flit_out_ready = 1'b0;
    bus.route_grant    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_packet(input logic [7:0] hdr, input logic [7:0] tail);
    int guard;
    for (int i = 0; i < 6; i++) begin
      bus.flit_in       = exp_flit(hdr, tail, i);
      bus.flit_in_valid = 1'b1;
      guard = 0;
      while (!bus.noc_ready && guard < 100) begin
        @(posedge clk);
        #1;
        guard++;
      end
      @(posedge clk);
      #1;
    end
    bus.flit_in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, output bit ok);
    int c = 0;
    while (out_q.size() < n && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    ok = (out_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_n              = 1'b0;
    bus.flit_in        = 8'h00;
    bus.flit_in_valid  = 1'b0;
    bus.flit_out_ready = 1'b0;
    bus.route_grant    = 1'b0;
    #1;
    checks++; if (bus.noc_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_noc_ready: got %b expected 1", bus.noc_ready); end
    checks++; if (bus.flit_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_flit_out_valid: got %b expected 0", bus.flit_out_valid); end
    checks++; if (bus.route_req !== 3'b000) begin failures++; $display("[TB] FAIL rst_route_req: got %b expected 000", bus.route_req); end
    checks++; if (bus.pkt_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_pkt_err: got %b expected 0", bus.pkt_err); end
    checks++; if (bus.occupancy !== 4'd0) begin failures++; $display("[TB] FAIL rst_occupancy: got %0d expected 0", bus.occupancy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int base;
    int eb;
    bit ok;
    apply_reset();
    base = out_q.size();
    eb   = err_cnt;
    bus.flit_out_ready = 1'b1;
    bus.route_grant    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.flit_in       = exp_flit(8'hBC, 8'hFF, i);
      bus.flit_in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0) begin
        checks++; if (bus.occupancy !== 4'd1) begin failures++; $display("[TB] FAIL t1_occ_first_push: got %0d expected 1", bus.occupancy); end
        checks++; if (bus.route_req !== 3'b000) begin failures++; $display("[TB] FAIL t1_req_too_early: got %b expected 000", bus.route_req); end
      end
      if (i == 1) begin
        checks++; if (bus.route_req !== 3'b001) begin failures++; $display("[TB] FAIL t1_req_local: got %b expected 001", bus.route_req); end
        checks++; if (bus.flit_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t1_valid_in_req: got %b expected 0", bus.flit_out_valid); end
      end
      if (i == 2) begin
        checks++; if (bus.flit_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL t1_latency_valid: got %b expected 1", bus.flit_out_valid); end
        checks++; if (bus.flit_out !== 8'hBC) begin failures++; $display("[TB] FAIL t1_latency_head: got %h expected bc", bus.flit_out); end
      end
    end
    bus.flit_in_valid = 1'b0;
    wait_out(base + 6, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL t1_timeout: got %0d flits expected 6", out_q.size() - base); end
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (out_q[base+i] !== exp_flit(8'hBC, 8'hFF, i)) begin failures++; $display("[TB] FAIL t1_flit%0d: got %h expected %h", i, out_q[base+i], exp_flit(8'hBC, 8'hFF, i)); end
        checks++; if (rr_q[base+i] !== 3'b001) begin failures++; $display("[TB] FAIL t1_req_held%0d: got %b expected 001", i, rr_q[base+i]); end
      end
    end
    @(posedge clk);
    #1;
    checks++; if (bus.route_req !== 3'b000) begin failures++; $display("[TB] FAIL t1_req_cleared: got %b expected 000", bus.route_req); end
    checks++; if (bus.flit_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t1_idle_valid: got %b expected 0", bus.flit_out_valid); end
    checks++; if (bus.occupancy !== 4'd0) begin failures++; $display("[TB] FAIL t1_idle_occ: got %0d expected 0", bus.occupancy); end
    checks++; if (err_cnt !== eb) begin failures++; $display("[TB] FAIL t1_no_err: got %0d pulses expected 0", err_cnt - eb); end
  endtask

  task automatic test_routes();
    logic [7:0] hdrs [3];
    logic [2:0] reqs [3];
    int base;
    int eb;
    bit ok;
    hdrs = '{8'hBD, 8'hBE, 8'hBF};
    reqs = '{3'b010, 3'b100, 3'b010};
    apply_reset();
    bus.flit_out_ready = 1'b1;
    bus.route_grant    = 1'b1;
    eb = err_cnt;
    for (int p = 0; p < 3; p++) begin
      base = out_q.size();
      send_packet(hdrs[p], 8'hFF);
      wait_out(base + 6, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL t2_timeout%0d: got %0d flits expected 6", p, out_q.size() - base); end
      if (ok) begin
        checks++; if (rr_q[base] !== reqs[p]) begin failures++; $display("[TB] FAIL t2_route_%h: got %b expected %b", hdrs[p], rr_q[base], reqs[p]); end
        checks++; if (rr_q[base+5] !== reqs[p]) begin failures++; $display("[TB] FAIL t2_route_held_%h: got %b expected %b", hdrs[p], rr_q[base+5], reqs[p]); end
        checks++; if (out_q[base] !== hdrs[p]) begin failures++; $display("[TB] FAIL t2_header_%h: got %h expected %h", hdrs[p], out_q[base], hdrs[p]); end
        checks++; if (out_q[base+5] !== 8'hFF) begin failures++; $display("[TB] FAIL t2_tail_%h: got %h expected ff", hdrs[p], out_q[base+5]); end
      end
    end
    checks++; if (err_cnt !== eb) begin failures++; $display("[TB] FAIL t2_no_err: got %0d pulses expected 0", err_cnt - eb); end
  endtask

  task automatic test_full();
    logic [7:0] pkt9 [9];
    int base;
    int eb;
    bit ok;
    pkt9 = '{8'hBC, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hBC, 8'h11, 8'h22};
    apply_reset();
    base = out_q.size();
    eb   = err_cnt;
    for (int i = 0; i < 9; i++) begin
      bus.flit_in       = pkt9[i];
      bus.flit_in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (i == 6) begin
        checks++; if (bus.noc_ready !== 1'b1) begin failures++; $display("[TB] FAIL t3_ready_at7: got %b expected 1", bus.noc_ready); end
      end
      if (i >= 7) begin
        checks++; if (bus.noc_ready !== 1'b0) begin failures++; $display("[TB] FAIL t3_full_ready%0d: got %b expected 0", i, bus.noc_ready); end
        checks++; if (bus.occupancy !== 4'd8) begin failures++; $display("[TB] FAIL t3_full_occ%0d: got %0d expected 8", i, bus.occupancy); end
      end
    end
    bus.flit_in_valid = 1'b0;
    bus.route_grant   = 1'b1;
    @(posedge clk);
    #1;
    bus.route_grant = 1'b0;
    checks++; if (bus.flit_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL t3_fwd_valid: got %b expected 1", bus.flit_out_valid); end
    checks++; if (bus.noc_ready !== 1'b0) begin failures++; $display("[TB] FAIL t3_full_during_pop: got %b expected 0", bus.noc_ready); end
    bus.flit_out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.flit_out_ready = 1'b0;
    checks++; if (bus.occupancy !== 4'd7) begin failures++; $display("[TB] FAIL t3_occ_after_pop: got %0d expected 7", bus.occupancy); end
    checks++; if (bus.noc_ready !== 1'b1) begin failures++; $display("[TB] FAIL t3_ready_after_pop: got %b expected 1", bus.noc_ready); end
    bus.flit_out_ready = 1'b1;
    bus.route_grant    = 1'b1;
    wait_out(base + 6, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL t3_timeout: got %0d flits expected 6", out_q.size() - base); end
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (out_q[base+i] !== pkt9[i]) begin failures++; $display("[TB] FAIL t3_flit%0d: got %h expected %h", i, out_q[base+i], pkt9[i]); end
      end
    end
    checks++; if (err_cnt !== eb) begin failures++; $display("[TB] FAIL t3_no_err: got %0d pulses expected 0", err_cnt - eb); end
  endtask

  task automatic test_stray();
    int base;
    int eb;
    bit ok;
    apply_reset();
    base = out_q.size();
    eb   = err_cnt;
    bus.flit_out_ready = 1'b1;
    bus.route_grant    = 1'b1;
    bus.flit_in        = 8'h55;
    bus.flit_in_valid  = 1'b1;
    @(posedge clk);
    #1;
    send_packet(8'hBC, 8'hFF);
    wait_out(base + 6, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL t4_timeout: got %0d flits expected 6", out_q.size() - base); end
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (out_q[base+i] !== exp_flit(8'hBC, 8'hFF, i)) begin failures++; $display("[TB] FAIL t4_flit%0d: got %h expected %h", i, out_q[base+i], exp_flit(8'hBC, 8'hFF, i)); end
      end
      checks++; if (rr_q[base] !== 3'b001) begin failures++; $display("[TB] FAIL t4_route: got %b expected 001", rr_q[base]); end
    end
    checks++; if (err_cnt !== eb + 1) begin failures++; $display("[TB] FAIL t4_err_pulses: got %0d expected 1", err_cnt - eb); end
  endtask

  task automatic test_bad_tail();
    int base;
    int eb;
    bit ok;
    apply_reset();
    base = out_q.size();
    eb   = err_cnt;
    bus.flit_out_ready = 1'b1;
    bus.route_grant    = 1'b1;
    send_packet(8'hBC, 8'h00);
    wait_out(base + 6, ok);
    @(posedge clk);
    #1;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL t5_timeout: got %0d flits expected 6", out_q.size() - base); end
    if (ok) begin
      checks++; if (out_q[base+5] !== 8'h00) begin failures++; $display("[TB] FAIL t5_bad_tail_fwd: got %h expected 00", out_q[base+5]); end
    end
    checks++; if (err_cnt !== eb + 1) begin failures++; $display("[TB] FAIL t5_err_pulse: got %0d expected 1", err_cnt - eb); end
    send_packet(8'hBC, 8'hFF);
    wait_out(base + 12, ok);
    @(posedge clk);
    #1;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL t5_timeout2: got %0d flits expected 12", out_q.size() - base); end
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (out_q[base+6+i] !== exp_flit(8'hBC, 8'hFF, i)) begin failures++; $display("[TB] FAIL t5_next_flit%0d: got %h expected %h", i, out_q[base+6+i], exp_flit(8'hBC, 8'hFF, i)); end
      end
      checks++; if (rr_q[base+6] !== 3'b001) begin failures++; $display("[TB] FAIL t5_next_route: got %b expected 001", rr_q[base+6]); end
    end
    checks++; if (err_cnt !== eb + 1) begin failures++; $display("[TB] FAIL t5_next_no_err: got %0d expected 1", err_cnt - eb); end
  endtask

  task automatic test_reset_mid();
    int base;
    int eb;
    bit ok;
    apply_reset();
    base = out_q.size();
    bus.flit_out_ready = 1'b0;
    bus.route_grant    = 1'b1;
    send_packet(8'hBC, 8'hFF);
    bus.flit_out_ready = 1'b1;
    wait_out(base + 3, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL t6_timeout: got %0d flits expected 3", out_q.size() - base); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.noc_ready !== 1'b1) begin failures++; $display("[TB] FAIL t6_noc_ready: got %b expected 1", bus.noc_ready); end
    checks++; if (bus.flit_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t6_flit_out_valid: got %b expected 0", bus.flit_out_valid); end
    checks++; if (bus.route_req !== 3'b000) begin failures++; $display("[TB] FAIL t6_route_req: got %b expected 000", bus.route_req); end
    checks++; if (bus.pkt_err !== 1'b0) begin failures++; $display("[TB] FAIL t6_pkt_err: got %b expected 0", bus.pkt_err); end
    checks++; if (bus.occupancy !== 4'd0) begin failures++; $display("[TB] FAIL t6_occupancy: got %0d expected 0", bus.occupancy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = out_q.size();
    eb   = err_cnt;
    send_packet(8'hBE, 8'hFF);
    wait_out(base + 6, ok);
    @(posedge clk);
    #1;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL t6_timeout2: got %0d flits expected 6", out_q.size() - base); end
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (out_q[base+i] !== exp_flit(8'hBE, 8'hFF, i)) begin failures++; $display("[TB] FAIL t6_flit%0d: got %h expected %h", i, out_q[base+i], exp_flit(8'hBE, 8'hFF, i)); end
      end
      checks++; if (rr_q[base] !== 3'b100) begin failures++; $display("[TB] FAIL t6_route: got %b expected 100", rr_q[base]); end
    end
    checks++; if (err_cnt !== eb) begin failures++; $display("[TB] FAIL t6_no_err: got %0d pulses expected 0", err_cnt - eb); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_routes();
    test_full();
    test_stray();
    test_bad_tail();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
